// File: rtl/glyph_pipe.sv
// glyph_pipe -- text-mode pixel pipeline for the VGA character display.
//
// Each cycle a raster coordinate is mapped to a text cell. The character code
// is read from a synchronous text RAM, and the glyph row is then read from a
// synchronous font ROM. One monochrome pixel is emitted, with a fixed latency
// of 4 cycles and a throughput of one pixel per cycle.
//
// Optional feature macro: GLYPH_CURSOR_EN
//   When defined, the cell at (cursor_col, cursor_row) is inverted during the
//   odd blink phase. The blink phase toggles every BLINK_FRAMES frame starts.
//   When undefined, no cursor logic is built.
//
// Ports:
//   clk         pixel clock, rising edge
//   rst_n       asynchronous active-low reset
//   horizontal  pixel column
//   vertical    pixel line
//   in_valid    coordinate lies in the active display
//   txtAddr     text RAM read address (row*COLS + col)
//   ascii       text RAM read data, 1-cycle latency
//   glyphAddr   font ROM address {char, glyph line}
//   bitmap      font ROM row, 1-cycle latency, MSB = leftmost pixel
//   cursor_col  cursor column (cell units)
//   cursor_row  cursor row (cell units)
//   pix         output pixel, 1 = foreground
//   pix_valid   pix is meaningful
module glyph_pipe #(
  parameter int COLS         = 80,
  parameter int ROWS         = 60,
  parameter int GLYPH_W_LOG2 = 3,
  parameter int GLYPH_H_LOG2 = 3,
  parameter int CHAR_W       = 8,
  parameter int TXT_AW       = 13,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [9:0]                     horizontal,
  input  logic [8:0]                     vertical,
  input  logic                           in_valid,
  output logic [TXT_AW-1:0]              txtAddr,
  input  logic [CHAR_W-1:0]              ascii,
  output logic [CHAR_W+GLYPH_H_LOG2-1:0] glyphAddr,
  input  logic [(1<<GLYPH_W_LOG2)-1:0]   bitmap,
  input  logic [7:0]                     cursor_col,
  input  logic [7:0]                     cursor_row,
  output logic                           pix,
  output logic                           pix_valid
);

  localparam int XW = GLYPH_W_LOG2;
  localparam int YW = GLYPH_H_LOG2;

  logic [9:0]    col;
  logic [8:0]    row;
  logic [31:0]   addr_full;
  logic          coord_ok;
  logic [XW-1:0] xoff;
  logic [YW-1:0] yoff;
  logic          cursor_match;

  assign col       = horizontal >> GLYPH_W_LOG2;
  assign row       = vertical >> GLYPH_H_LOG2;
  assign addr_full = 32'(row) * 32'(COLS) + 32'(col);
  assign coord_ok  = in_valid && (32'(col) < 32'(COLS)) && (32'(row) < 32'(ROWS));
  assign xoff      = horizontal[XW-1:0];
  assign yoff      = vertical[YW-1:0];

`ifdef GLYPH_CURSOR_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] frame_cnt;
  logic          blink_phase;
  logic          frame_start;

  assign frame_start = in_valid && (horizontal == 10'd0) && (vertical == 9'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + FW'(1);
      end
    end
  end

  assign cursor_match = (col == {2'b00, cursor_col}) &&
                        (row == {1'b0, cursor_row}) && blink_phase;
`else
  // Cursor disabled: the inputs are folded into a constant-zero term.
  assign cursor_match = &{1'b0, cursor_col, cursor_row, (BLINK_FRAMES > 0)};
`endif

  // Side-band pipeline: a (after E0), b (E1), c (E2), d (E3).
  logic [XW-1:0] a_xoff, b_xoff, c_xoff, d_xoff;
  logic [YW-1:0] a_yoff, b_yoff;
  logic          a_valid, b_valid, c_valid, d_valid;
  logic          a_cur, b_cur, c_cur, d_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txtAddr   <= '0;
      glyphAddr <= '0;
      pix       <= 1'b0;
      pix_valid <= 1'b0;
      a_xoff    <= '0;
      b_xoff    <= '0;
      c_xoff    <= '0;
      d_xoff    <= '0;
      a_yoff    <= '0;
      b_yoff    <= '0;
      a_valid   <= 1'b0;
      b_valid   <= 1'b0;
      c_valid   <= 1'b0;
      d_valid   <= 1'b0;
      a_cur     <= 1'b0;
      b_cur     <= 1'b0;
      c_cur     <= 1'b0;
      d_cur     <= 1'b0;
    end else begin
      // Stage A: address the text RAM. The address holds on blank samples.
      if (coord_ok) txtAddr <= addr_full[TXT_AW-1:0];
      a_xoff  <= xoff;
      a_yoff  <= yoff;
      a_valid <= coord_ok;
      a_cur   <= coord_ok & cursor_match;
      // Stage B: text RAM read in flight.
      b_xoff  <= a_xoff;
      b_yoff  <= a_yoff;
      b_valid <= a_valid;
      b_cur   <= a_cur;
      // Stage C: the character code is available; address the font ROM.
      glyphAddr <= {ascii, b_yoff};
      c_xoff    <= b_xoff;
      c_valid   <= b_valid;
      c_cur     <= b_cur;
      // Stage D: font ROM read in flight.
      d_xoff  <= c_xoff;
      d_valid <= c_valid;
      d_cur   <= c_cur;
      // Stage E: select the pixel. ~xoff equals (width-1-xoff) for a
      // power-of-two width, so MSB is the leftmost pixel.
      pix       <= d_valid & (bitmap[~d_xoff] ^ d_cur);
      pix_valid <= d_valid;
    end
  end

endmodule

// File: tb/tb_glyph_pipe.sv
module tb_glyph_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  horizontal;
  logic [8:0]  vertical;
  logic        in_valid;
  logic [12:0] txtAddr, txtAddr2;
  logic [7:0]  ascii, ascii2;
  logic [10:0] glyphAddr;
  logic [11:0] glyphAddr2;
  logic [7:0]  bitmap;
  logic [15:0] bitmap2;
  logic [7:0]  cursor_col, cursor_row;
  logic        pix, pix_valid, pix2, pix_valid2;

  glyph_pipe dut (
    .clk(clk), .rst_n(rst_n), .horizontal(horizontal), .vertical(vertical),
    .in_valid(in_valid), .txtAddr(txtAddr), .ascii(ascii), .glyphAddr(glyphAddr),
    .bitmap(bitmap), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .pix(pix), .pix_valid(pix_valid)
  );

  glyph_pipe #(.COLS(40), .ROWS(30), .GLYPH_W_LOG2(4), .GLYPH_H_LOG2(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .horizontal(horizontal), .vertical(vertical),
    .in_valid(in_valid), .txtAddr(txtAddr2), .ascii(ascii2), .glyphAddr(glyphAddr2),
    .bitmap(bitmap2), .cursor_col(cursor_col), .cursor_row(cursor_row),
    .pix(pix2), .pix_valid(pix_valid2)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem   [8192];
  logic [7:0]  mem2  [8192];
  logic [7:0]  font  [2048];
  logic [15:0] font2 [4096];

  always @(posedge clk) begin
    ascii   <= mem[txtAddr];
    ascii2  <= mem2[txtAddr2];
    bitmap  <= font[glyphAddr];
    bitmap2 <= font2[glyphAddr2];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int due; bit pix;} exp_t;
  exp_t q[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops an expected pixel whenever the DUT presents pix_valid.
  always @(negedge clk) begin
    exp_t e;
    if (pix_valid) begin
      if (q.size() == 0) begin
        chk("spurious_pix_valid", 1, 0);
      end else begin
        e = q.pop_front();
        chk("pix_latency", cyc, e.due);
        chk("pix_value", int'(pix), int'(e.pix));
      end
    end else if (pix) begin
      chk("pix_when_invalid", int'(pix), 0);
    end
  end

  task automatic issue(input int h, input int v, input bit val, input bit pv, input bit px);
    horizontal = 10'(h);
    vertical   = 9'(v);
    in_valid   = val;
    @(posedge clk);
    #1;
    if (pv) q.push_back('{due: cyc + 4, pix: px});
  endtask

  task automatic cell_row(input logic [7:0] pat);
    for (int i = 0; i < 8; i++) issue(16 + i, 8, 1'b1, 1'b1, pat[7-i]);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pix"}, int'(pix), 0);
    chk({tag, "_pix_valid"}, int'(pix_valid), 0);
    chk({tag, "_txtAddr"}, int'(txtAddr), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cur_pat;
    for (int i = 0; i < 8192; i++) begin mem[i] = 8'h00; mem2[i] = 8'h00; end
    for (int i = 0; i < 2048; i++) font[i] = 8'h00;
    for (int i = 0; i < 4096; i++) font2[i] = 16'h0000;
    mem[0]    = 8'h01;
    mem[82]   = 8'h41;
    mem2[42]  = 8'h5A;
    font[(8'h01 << 3) | 0] = 8'h80;
    font[(8'h41 << 3) | 0] = 8'h80;
    font[(8'h41 << 3) | 1] = 8'h3C;

    rst_n = 1'b0; horizontal = '0; vertical = '0; in_valid = 1'b0;
    cursor_col = 8'd2; cursor_row = 8'd1;

    // Reset held while coordinates sweep.
    for (int i = 0; i < 5; i++) begin
      issue(i * 8, 0, 1'b1, 1'b0, 1'b0);
      reset_checks("reset_hold");
    end
    rst_n = 1'b1;
    // Mid-line reset: these samples must never emerge.
    issue(8, 0, 1'b1, 1'b0, 1'b0);
    issue(16, 0, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_checks("reset_async");
    for (int i = 0; i < 5; i++) begin
      issue(24 + i * 8, 0, 1'b1, 1'b0, 1'b0);
      reset_checks("reset_mid");
    end
    rst_n = 1'b1;
    issue(0, 0, 1'b1, 1'b1, 1'b1);
    issue(1, 0, 1'b1, 1'b1, 1'b0);

    // Address math: cell (2,1) -> 82, char 0x41 line 1 -> 0x209.
    issue(17, 9, 1'b1, 1'b1, 1'b0);
    chk("txtAddr_17_9", int'(txtAddr), 82);
    issue(18, 9, 1'b1, 1'b1, 1'b1);
    issue(640, 9, 1'b1, 1'b0, 1'b0);
    chk("glyphAddr_41_1", int'(glyphAddr), 'h209);
    chk("txtAddr_hold_col_oob", int'(txtAddr), 82);
    issue(17, 480, 1'b1, 1'b0, 1'b0);
    chk("txtAddr_hold_row_oob", int'(txtAddr), 82);
    issue(17, 9, 1'b0, 1'b0, 1'b0);
    chk("txtAddr_hold_invalid", int'(txtAddr), 82);

    // Bit order: 0x80 row -> 1,0,0,0,0,0,0,0.
    for (int i = 0; i < 8; i++) issue(i, 0, 1'b1, 1'b1, (i == 0));

    // Geometry: 16x16 glyphs, 40 columns.
    issue(35, 20, 1'b1, 1'b1, 1'b0);
    chk("txtAddr_default_35_20", int'(txtAddr), 164);
    chk("txtAddr2_35_20", int'(txtAddr2), 42);
    issue(640, 0, 1'b1, 1'b0, 1'b0);
    issue(640, 0, 1'b1, 1'b0, 1'b0);
    chk("glyphAddr2_5A_4", int'(glyphAddr2), 'h5A4);
    chk("glyphAddr_00_4", int'(glyphAddr), 'h004);

    // Raster wrap: last cell then origin, back to back.
    issue(639, 479, 1'b1, 1'b1, 1'b0);
    issue(0, 0, 1'b1, 1'b1, 1'b1);

    // Drain, then restart from reset for the blink sequence.
    for (int i = 0; i < 6; i++) issue(640, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    issue(640, 0, 1'b0, 1'b0, 1'b0);
    issue(640, 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    cell_row(8'b1000_0000);
    for (int i = 0; i < 30; i++) issue(0, 0, 1'b1, 1'b1, 1'b1);
`ifdef GLYPH_CURSOR_EN
    cur_pat = 8'b0111_1111;
`else
    cur_pat = 8'b1000_0000;
`endif
    cell_row(cur_pat);
    for (int i = 0; i < 30; i++) issue(0, 0, 1'b1, 1'b1, 1'b1);
    cell_row(8'b1000_0000);

    for (int i = 0; i < 6; i++) issue(640, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
